washing_machine_control: RTL and testbench
==========================================

Name: washing_machine_control

Overview:
Moore-style finite state machine that sequences one washing-machine programme: pre-drain, fill, agitate, spin, settle. Each phase ends on a done pulse from an external phase timer. The block drives the actuator outputs (agitator, motor, pump, speed, water_fill) and a one-cycle timer-restart pulse. It sits between the front-panel/door sensors, the shared phase timer and the actuator drivers.

Parameters:
None. All behaviour is fixed.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
td  input  1  drain-timer done (level, sampled only in DRAIN)
tf  input  1  fill-timer done (sampled only in FILL)
tr  input  1  agitate/run-timer done (sampled only in AGITATE)
ts  input  1  spin-timer done (sampled only in SPIN)
tw  input  1  settle/wait-timer done (sampled only in SETTLE)
door  input  1  1 = door open, 0 = closed
start  input  1  programme start request (level)
agitator  output  1  agitator drive
motor  output  1  drum motor enable
pump  output  1  drain pump enable
speed  output  1  motor speed: 0 = low (wash), 1 = high (spin)
water_fill  output  1  inlet valve open
reset  output  1  one-cycle pulse telling the external phase timer to restart

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- All outputs are registered and decoded from the state register.
- rst=1 at a clock edge: state goes to IDLE and every output is 0 on the following cycle. rst has priority over all other inputs.
- States (3-bit encoding, unused codes go to IDLE): IDLE, DRAIN, FILL, AGITATE, SPIN, SETTLE, PAUSE.
- IDLE: all outputs 0. If start=1 and door=0, go to DRAIN. start while door=1 is ignored and not remembered.
- DRAIN: pump=1. td=1 moves to FILL.
- FILL: water_fill=1. tf=1 moves to AGITATE.
- AGITATE: agitator=1, motor=1, speed=0. tr=1 moves to SPIN.
- SPIN: pump=1, motor=1, speed=1. ts=1 moves to SETTLE.
- SETTLE: all actuators 0. tw=1 moves to IDLE.
- start is level-sensitive. If it is still 1 on the cycle after returning to IDLE (and door=0), a new programme starts.
- Timer inputs are honoured only in their own state. Others are ignored, including when several are asserted together.
- reset output: 1 for exactly one cycle, in the first cycle of each newly entered DRAIN/FILL/AGITATE/SPIN/SETTLE. It is 0 in IDLE and PAUSE, and it is not pulsed when resuming from PAUSE.
- Latency: an input change at edge N is reflected on the outputs after edge N+1 (single register stage).
- start is not required after leaving IDLE. Dropping it mid-programme does not abort.

Optional Feature:
DOOR_PAUSE_EN
- Defined: door=1 in any active state (DRAIN..SETTLE) moves to PAUSE. The interrupted state is saved.
  - In PAUSE, all outputs are 0 and timer inputs are ignored.
  - door=0 returns to the saved state, with its outputs and no reset pulse.
  - rst in PAUSE goes to IDLE.
- Not defined: door is checked only in IDLE. Once the programme has started, door has no effect and the PAUSE state is not built.

Test Plan:
1. Assert rst with start=1: the cycle after rst, all outputs are 0 and the state is IDLE. Release rst with start=1 and door=0: next cycle pump=1 and reset=1 for one cycle.
2. start=1, door=0, then one-cycle pulses of td, tf, tr, ts, tw in turn. Required outputs: pump → water_fill → agitator+motor, speed=0 → pump+motor, speed=1 → all 0 → IDLE. reset pulses once per phase.
3. Hold start=1 and repeat the pulse train 8 times: 8 complete programmes, agitator high exactly 8 times.
4. In DRAIN, assert ts and tw, then tf: state stays DRAIN and pump stays 1. Then td=1: FILL.
5. door=1 with start=1 in IDLE: no transition and outputs stay 0. Drop door to 0 with start still 1: DRAIN.
6. DOOR_PAUSE_EN defined: door=1 during SPIN → all outputs 0. door=0 → pump=1, motor=1, speed=1 again with no reset pulse. Without the macro, the same stimulus keeps the SPIN outputs throughout.

Source files
------------

// File: rtl/washing_machine_control.sv
// Washing-machine programme sequencer: IDLE -> DRAIN -> FILL -> AGITATE -> SPIN -> SETTLE.
// Optional macro DOOR_PAUSE_EN adds a PAUSE state entered on door-open during a programme.
module washing_machine_control (
  input  logic clk,
  input  logic rst,
  input  logic td,
  input  logic tf,
  input  logic tr,
  input  logic ts,
  input  logic tw,
  input  logic door,
  input  logic start,
  output logic agitator,
  output logic motor,
  output logic pump,
  output logic speed,
  output logic water_fill,
  output logic reset
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_FILL    = 3'd2,
    S_AGITATE = 3'd3,
    S_SPIN    = 3'd4,
    S_SETTLE  = 3'd5,
    S_PAUSE   = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic r_agitator, r_motor, r_pump, r_speed, r_water_fill, r_reset;
  logic w_agitator, w_motor, w_pump, w_speed, w_water_fill, w_reset;

`ifdef DOOR_PAUSE_EN
  state_t r_saved;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start && !door) w_state_next = S_DRAIN;
      S_DRAIN:   if (td) w_state_next = S_FILL;
      S_FILL:    if (tf) w_state_next = S_AGITATE;
      S_AGITATE: if (tr) w_state_next = S_SPIN;
      S_SPIN:    if (ts) w_state_next = S_SETTLE;
      S_SETTLE:  if (tw) w_state_next = S_IDLE;
`ifdef DOOR_PAUSE_EN
      S_PAUSE:   if (!door) w_state_next = r_saved;
`endif
      default:   w_state_next = S_IDLE;
    endcase
`ifdef DOOR_PAUSE_EN
    // An open door wins over a timer done arriving in the same cycle.
    if (door && (r_state inside {S_DRAIN, S_FILL, S_AGITATE, S_SPIN, S_SETTLE}))
      w_state_next = S_PAUSE;
`endif
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    w_agitator   = 1'b0;
    w_motor      = 1'b0;
    w_pump       = 1'b0;
    w_speed      = 1'b0;
    w_water_fill = 1'b0;
    case (w_state_next)
      S_DRAIN:   w_pump = 1'b1;
      S_FILL:    w_water_fill = 1'b1;
      S_AGITATE: begin
        w_agitator = 1'b1;
        w_motor    = 1'b1;
      end
      S_SPIN: begin
        w_pump  = 1'b1;
        w_motor = 1'b1;
        w_speed = 1'b1;
      end
      default: ;
    endcase
    w_reset = (w_state_next != r_state) && (r_state != S_PAUSE) &&
              (w_state_next inside {S_DRAIN, S_FILL, S_AGITATE, S_SPIN, S_SETTLE});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_agitator   <= 1'b0;
      r_motor      <= 1'b0;
      r_pump       <= 1'b0;
      r_speed      <= 1'b0;
      r_water_fill <= 1'b0;
      r_reset      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_agitator   <= w_agitator;
      r_motor      <= w_motor;
      r_pump       <= w_pump;
      r_speed      <= w_speed;
      r_water_fill <= w_water_fill;
      r_reset      <= w_reset;
    end
  end

`ifdef DOOR_PAUSE_EN
  always_ff @(posedge clk) begin
    if (rst)
      r_saved <= S_IDLE;
    else if (w_state_next == S_PAUSE && r_state != S_PAUSE)
      r_saved <= r_state;
  end
`endif

  assign agitator   = r_agitator;
  assign motor      = r_motor;
  assign pump       = r_pump;
  assign speed      = r_speed;
  assign water_fill = r_water_fill;
  assign reset      = r_reset;

endmodule

// File: tb/tb_washing_machine_control.sv
// Scoreboard bench for washing_machine_control: a phase-index reference model pushes expected
// outputs per cycle; an independent monitor pops and compares after each rising edge.
module tb_washing_machine_control;

  logic clk = 1'b0;
  logic rst, td, tf, tr, ts, tw, door, start;
  logic agitator, motor, pump, speed, water_fill, reset;

  washing_machine_control dut (
    .clk(clk), .rst(rst), .td(td), .tf(tf), .tr(tr), .ts(ts), .tw(tw),
    .door(door), .start(start),
    .agitator(agitator), .motor(motor), .pump(pump), .speed(speed),
    .water_fill(water_fill), .reset(reset)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cycle  = 0;
  int ag_rises = 0;
  bit prev_ag  = 1'b0;

  // Expected {agitator, motor, pump, speed, water_fill, reset} after the next edge.
  logic [5:0] exp_q[$];

  // Reference model: programme position as a phase number, 0 = idle, 1..5 = drain..settle.
  int m_phase  = 0;
  bit m_paused = 1'b0;
  bit m_pulse  = 1'b0;
  logic [4:0] phase_out[0:5];

  initial begin
    phase_out[0] = 5'b00000;
    phase_out[1] = 5'b00100;  // drain: pump
    phase_out[2] = 5'b00001;  // fill: water valve
    phase_out[3] = 5'b11000;  // agitate: agitator + motor, low speed
    phase_out[4] = 5'b01110;  // spin: pump + motor, high speed
    phase_out[5] = 5'b00000;  // settle: everything off
  end

  function automatic logic [5:0] model_step(input bit r, input bit st, input bit dr,
                                            input logic [4:0] t);
    m_pulse = 1'b0;
    if (r) begin
      m_phase  = 0;
      m_paused = 1'b0;
    end else if (m_paused) begin
      if (!dr) m_paused = 1'b0;
    end else if (m_phase == 0) begin
      if (st && !dr) begin
        m_phase = 1;
        m_pulse = 1'b1;
      end
    end else begin
`ifdef DOOR_PAUSE_EN
      if (dr) m_paused = 1'b1;
      else
`endif
      if (t[m_phase-1]) begin
        m_phase = (m_phase + 1) % 6;
        m_pulse = (m_phase != 0);
      end
    end
    if (m_paused) return 6'b0;
    return {phase_out[m_phase], m_pulse};
  endfunction

  // One cycle of stimulus; t = {tw, ts, tr, tf, td}.
  task automatic cyc(input bit r, input bit st, input bit dr, input logic [4:0] t);
    @(negedge clk);
    rst = r; start = st; door = dr;
    {tw, ts, tr, tf, td} = t;
    exp_q.push_back(model_step(r, st, dr, t));
  endtask

  task automatic programme();
    cyc(0, 1, 0, 5'b0);
    for (int p = 0; p < 5; p++) begin
      cyc(0, 1, 0, 5'b1 << p);
      cyc(0, 1, 0, 5'b0);
    end
  endtask

  always begin
    logic [5:0] exp_v, act_v;
    @(posedge clk);
    #1;
    n_cycle++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {agitator, motor, pump, speed, water_fill, reset};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got {ag,mo,pu,sp,wf,rs}=%b required %b",
                 n_cycle, act_v, exp_v);
      end
    end
    if (agitator === 1'b1 && !prev_ag) ag_rises++;
    prev_ag = (agitator === 1'b1);
  end

  initial begin
    int rises0;
    rst = 1'b1; start = 1'b0; door = 1'b0;
    {tw, ts, tr, tf, td} = 5'b0;

    // Reset with start held, then release: drain with restart pulse.
    cyc(1, 1, 0, 5'b0);
    cyc(1, 1, 0, 5'b11111);
    cyc(0, 1, 0, 5'b0);
    cyc(0, 1, 0, 5'b0);

    // One full programme.
    cyc(1, 0, 0, 5'b0);
    programme();

    // Eight back-to-back programmes with start held.
    cyc(1, 0, 0, 5'b0);
    rises0 = ag_rises;
    for (int k = 0; k < 8; k++) programme();
    @(posedge clk); #2;
    n_checks++;
    if (ag_rises - rises0 != 8) begin
      n_fail++;
      $display("FAIL agitator_count: got %0d required 8", ag_rises - rises0);
    end

    // Foreign timers in DRAIN are ignored.
    cyc(1, 0, 0, 5'b0);
    cyc(0, 1, 0, 5'b0);
    cyc(0, 0, 0, 5'b11000);
    cyc(0, 0, 0, 5'b00010);
    cyc(0, 0, 0, 5'b11110);
    cyc(0, 0, 0, 5'b00001);
    cyc(0, 0, 0, 5'b0);

    // Start with door open is ignored, then honoured once the door closes.
    cyc(1, 0, 0, 5'b0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 5'b0);
    cyc(0, 1, 0, 5'b0);
    cyc(0, 0, 0, 5'b0);

    // Door opened during SPIN.
    cyc(1, 0, 0, 5'b0);
    cyc(0, 1, 0, 5'b0);
    cyc(0, 0, 0, 5'b00001);
    cyc(0, 0, 0, 5'b00010);
    cyc(0, 0, 0, 5'b00100);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 5'b01000);
    cyc(0, 0, 0, 5'b0);
    cyc(0, 0, 0, 5'b0);
    cyc(0, 0, 0, 5'b01000);
    cyc(0, 0, 0, 5'b0);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      bit r, st, dr;
      logic [4:0] t;
      r  = ($urandom_range(0, 99) < 1);
      st = ($urandom_range(0, 99) < 60);
      dr = ($urandom_range(0, 99) < 8);
      for (int b = 0; b < 5; b++) t[b] = ($urandom_range(0, 99) < 30);
      cyc(r, st, dr, t);
    end

    @(posedge clk); #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
